fnv_hash_sequencer: RTL and testbench

Sequences the FNV-1a 32-bit hash datapath between the two I2C-side FIFOs in the system clock domain. Pops message bytes from the to-hasher FIFO read port, folds each into a running FNV-1a state, and on an end-of-message command pushes the 32-bit digest into the from-hasher FIFO write port. Owns all hash context (offset basis, length, pending finish) so the I2C peripheral only moves bytes and commands.

---
 rtl/fnv_hash_sequencer_if.sv | 50 +++++
 rtl/fnv_hash_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fnv_hash_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnv_hash_sequencer_if.sv
// fnv_hash_sequencer_if
//
// Bundles the two FIFO ports the hash sequencer talks to, both in the
// system clock domain:
//   byte FIFO read port (first-word fall-through):
//     in_data  [7:0]  head byte, meaningful whenever in_empty = 0
//     in_empty        byte FIFO has nothing to offer
//     in_pop          consume the head byte at this clock edge
//   digest FIFO write port:
//     out_data [31:0] digest to write
//     out_full        digest FIFO cannot accept a write
//     out_push        write out_data at this clock edge
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// exactly when the request (in_pop / out_push) is high in that cycle. The
// requester only raises it when the other side can take part (in_empty = 0
// for a pop, out_full = 0 for a push). Once out_push may assert, out_data is
// stable. A pending push is not required to stay up; it may be withdrawn
// (abort), in which case no transfer occurs.
//
// Modports:
//   master - the hash sequencer (drives in_pop, out_push, out_data)
//   slave  - the FIFO side (drives in_data, in_empty, out_full)

interface fnv_hash_sequencer_if;
    logic [7:0]  in_data;
    logic        in_empty;
    logic        in_pop;
    logic [31:0] out_data;
    logic        out_full;
    logic        out_push;

    modport master (
        input  in_data,
        input  in_empty,
        input  out_full,
        output in_pop,
        output out_data,
        output out_push
    );

    modport slave (
        output in_data,
        output in_empty,
        output out_full,
        input  in_pop,
        input  out_data,
        input  out_push
    );
endinterface

// File: rtl/fnv_hash_sequencer.sv
// fnv_hash_sequencer
//
// Sequences an FNV-1a 32-bit hash between a byte FIFO and a digest FIFO.
// Bytes are popped and folded into the running hash one per clock while the
// sequencer is in ACCUM. An end-of-message pulse (finish) is remembered in
// finish_pending; once the byte FIFO has drained, the hash is captured into
// out_data and the sequencer moves to EMIT, where it pushes the digest as
// soon as the digest FIFO has room. All message context (hash, length,
// pending finish) lives here.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   fifo           byte FIFO read port + digest FIFO write port (master side)
//   finish         single-cycle end-of-message pulse
//   abort          single-cycle pulse, discards the current message
//   busy           EMIT, a finish pending, or bytes waiting in the byte FIFO
//   msg_len        bytes absorbed into the current message, saturating
//   digest_count   digests pushed since reset, wrapping
//   finish_overrun sticky: finish arrived while one was pending or emitting
//   state_dbg      current FSM state (0 = ACCUM, 1 = EMIT)

module fnv_hash_sequencer (
    input  logic                        clk,
    input  logic                        reset,
    fnv_hash_sequencer_if.master        fifo,
    input  logic                        finish,
    input  logic                        abort,
    output logic                        busy,
    output logic [15:0]                 msg_len,
    output logic [7:0]                  digest_count,
    output logic                        finish_overrun,
    output logic                        state_dbg
);

    localparam logic [31:0] FNV_BASIS   = 32'h811C9DC5;
    localparam logic [15:0] MSG_LEN_MAX = 16'hFFFF;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hash_q, hash_d;
    logic        finish_pending_q, finish_pending_d;
    logic [31:0] out_data_q, out_data_d;
    logic [15:0] msg_len_q, msg_len_d;
    logic [7:0]  digest_count_q, digest_count_d;
    logic        overrun_q, overrun_d;

    logic        pop;
    logic        push;
    logic [31:0] hash_step;

    // One FNV-1a round. The multiply by the prime 0x01000193 is spelled out
    // as its set bits (24, 8, 7, 4, 1, 0) so it maps onto a single-cycle
    // adder tree; the sum is naturally truncated to 32 bits.
    function automatic logic [31:0] fnv_round(input logic [31:0] h,
                                              input logic [7:0]  b);
        logic [31:0] x;
        x = h ^ {24'h000000, b};
        return (x << 24) + (x << 8) + (x << 7) + (x << 4) + (x << 1) + x;
    endfunction

    assign hash_step = fnv_round(hash_q, fifo.in_data);

    // FIFO requests. These decode only the registered state plus the FIFO
    // status (and abort, which may withdraw a push). finish has no path to
    // in_pop, so a finish pulse never changes what is popped that cycle.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        case (state_q)
            ACCUM:   pop  = ~fifo.in_empty;
            EMIT:    push = ~fifo.out_full & ~abort;
            default: begin
                pop  = 1'b0;
                push = 1'b0;
            end
        endcase
    end

    // Next-state and register updates.
    always_comb begin
        state_d          = state_q;
        hash_d           = hash_q;
        finish_pending_d = finish_pending_q;
        out_data_d       = out_data_q;
        msg_len_d        = msg_len_q;
        digest_count_d   = digest_count_q;
        overrun_d        = overrun_q;

        if (abort) begin
            // Abort wins over everything except reset: a byte popped this
            // cycle is dropped, a finish this cycle is ignored, and a push
            // this cycle has already been withdrawn above.
            state_d          = ACCUM;
            hash_d           = FNV_BASIS;
            msg_len_d        = 16'h0000;
            finish_pending_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (pop) begin
                        hash_d = hash_step;
                        if (msg_len_q != MSG_LEN_MAX) begin
                            msg_len_d = msg_len_q + 16'd1;
                        end
                    end

                    // Bytes queued before the finish belong to this message,
                    // so the digest is only captured once the FIFO is empty.
                    // pop and this transition are mutually exclusive.
                    if (finish_pending_q && fifo.in_empty) begin
                        state_d    = EMIT;
                        out_data_d = hash_q;
                    end

                    if (finish) begin
                        if (finish_pending_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            finish_pending_d = 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (finish) begin
                        overrun_d = 1'b1;
                    end

                    if (push) begin
                        state_d          = ACCUM;
                        hash_d           = FNV_BASIS;
                        msg_len_d        = 16'h0000;
                        finish_pending_d = 1'b0;
                        digest_count_d   = digest_count_q + 8'd1;
                    end
                end

                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ACCUM;
            hash_q           <= FNV_BASIS;
            finish_pending_q <= 1'b0;
            out_data_q       <= 32'h00000000;
            msg_len_q        <= 16'h0000;
            digest_count_q   <= 8'h00;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            hash_q           <= hash_d;
            finish_pending_q <= finish_pending_d;
            out_data_q       <= out_data_d;
            msg_len_q        <= msg_len_d;
            digest_count_q   <= digest_count_d;
            overrun_q        <= overrun_d;
        end
    end

    assign fifo.in_pop    = pop;
    assign fifo.out_push  = push;
    assign fifo.out_data  = out_data_q;

    assign busy           = (state_q == EMIT) | finish_pending_q | ~fifo.in_empty;
    assign msg_len        = msg_len_q;
    assign digest_count   = digest_count_q;
    assign finish_overrun = overrun_q;
    assign state_dbg      = (state_q == EMIT);

endmodule

// File: tb/tb_fnv_hash_sequencer.sv
// tb_fnv_hash_sequencer
//
// Directed bench for fnv_hash_sequencer. A behavioural first-word
// fall-through byte FIFO feeds the DUT; expected digests come from a plain
// multiply-based FNV-1a reference and are queued when a finish is issued,
// then popped and compared whenever the DUT pushes.

module tb_fnv_hash_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic finish;
    logic abort;
    logic        busy;
    logic [15:0] msg_len;
    logic [7:0]  digest_count;
    logic        finish_overrun;
    logic        state_dbg;

    fnv_hash_sequencer_if bus ();

    fnv_hash_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .fifo           (bus),
        .finish         (finish),
        .abort          (abort),
        .busy           (busy),
        .msg_len        (msg_len),
        .digest_count   (digest_count),
        .finish_overrun (finish_overrun),
        .state_dbg      (state_dbg)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    // -------------------------------------------------------- bench state
    int          total = 0;
    int          bad   = 0;
    int          n_exp = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  byte_q[$];

    logic        s_pop, s_push, s_busy, s_ovr, s_state;
    logic [31:0] s_data;
    logic [15:0] s_len;
    logic [7:0]  s_count;

    // -------------------------------------------------------- reference
    function automatic logic [31:0] fnv_ref(input string s);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int i = 0; i < s.len(); i++) begin
            h = (h ^ {24'h000000, s[i]}) * 32'h01000193;
        end
        return h;
    endfunction

    // -------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // -------------------------------------------------------- drivers
    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte_q.push_back(s[i]);
        end
    endtask

    task automatic expect_digest(input string s);
        exp_q.push_back(fnv_ref(s));
        n_exp++;
    endtask

    // One clock cycle: present the FIFO head, sample the DUT at the falling
    // edge, score any push, retire a popped byte, then step past the rising
    // edge and drop the single-cycle pulses.
    task automatic run_cycle();
        logic [31:0] exp_d;
        bus.in_empty = (byte_q.size() == 0);
        bus.in_data  = (byte_q.size() == 0) ? 8'h00 : byte_q[0];
        @(negedge clk);
        s_pop   = bus.in_pop;
        s_push  = bus.out_push;
        s_data  = bus.out_data;
        s_busy  = busy;
        s_len   = msg_len;
        s_count = digest_count;
        s_ovr   = finish_overrun;
        s_state = state_dbg;
        if (s_push) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_push: observed push of %h, expected no push", s_data);
            end
            if (exp_q.size() != 0) begin
                exp_d = exp_q.pop_front();
                check("digest", s_data, exp_d);
            end
        end
        if (s_pop && byte_q.size() != 0) begin
            void'(byte_q.pop_front());
        end
        @(posedge clk);
        #1;
        finish = 1'b0;
        abort  = 1'b0;
    endtask

    // Runs cycles until a push is seen (bounded) and checks how many cycles
    // after the finish cycle it came; -1 means it never came.
    task automatic wait_push(input string tag, input int exp_lat);
        int cycles;
        cycles = -1;
        for (int i = 1; i <= exp_lat + 20; i++) begin
            run_cycle();
            if (s_push) begin
                cycles = i;
                break;
            end
        end
        check(tag, cycles, exp_lat);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_data"}, s_data, 32'h0);
        check({tag, "_msg_len"}, s_len, 32'h0);
        check({tag, "_digest_count"}, s_count, 32'h0);
        check({tag, "_overrun"}, s_ovr, 32'h0);
        check({tag, "_in_pop"}, s_pop, 32'h0);
        check({tag, "_out_push"}, s_push, 32'h0);
        check({tag, "_busy"}, s_busy, 32'h0);
        check({tag, "_state"}, s_state, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------- stimulus
    initial begin
        reset        = 1'b1;
        finish       = 1'b0;
        abort        = 1'b0;
        bus.out_full = 1'b0;
        bus.in_empty = 1'b1;
        bus.in_data  = 8'h00;

        run_cycle();
        run_cycle();
        reset = 1'b0;
        run_cycle();
        check_reset_values("reset");

        // Empty message: digest is the offset basis, push two cycles later.
        finish = 1'b1;
        expect_digest("");
        run_cycle();
        wait_push("empty_latency", 2);
        run_cycle();
        check("empty_digest_count", digest_count, n_exp);
        check("empty_msg_len", s_len, 32'h0);
        check("empty_state", s_state, 32'h0);

        // "a", finish the following cycle.
        push_str("a");
        run_cycle();
        check("a_pop", s_pop, 32'h1);
        finish = 1'b1;
        expect_digest("a");
        run_cycle();
        check("a_msg_len", s_len, 32'h1);
        wait_push("a_latency", 2);
        run_cycle();
        check("a_digest_count", s_count, n_exp);

        // "foobar" streamed with the FIFO never empty; finish with last byte.
        begin
            string s;
            s = "foobar";
            for (int i = 0; i < 6; i++) begin
                byte_q.push_back(s[i]);
                if (i == 5) begin
                    finish = 1'b1;
                    expect_digest("foobar");
                end
                run_cycle();
                check("foobar_pop", s_pop, 32'h1);
            end
        end
        run_cycle();
        check("foobar_held_push", s_push, 32'h0);
        check("foobar_held_data", s_data, fnv_ref("a"));
        check("foobar_busy", s_busy, 32'h1);
        run_cycle();
        check("foobar_push", s_push, 32'h1);
        run_cycle();
        check("foobar_count", s_count, n_exp);

        // "a" with the digest FIFO full for five cycles; a byte arrives and
        // a second finish lands during the stall.
        push_str("a");
        run_cycle();
        bus.out_full = 1'b1;
        finish = 1'b1;
        expect_digest("a");
        run_cycle();
        run_cycle();
        check("stall_pending_state", s_state, 32'h0);
        run_cycle();
        check("stall_emit_state", s_state, 32'h1);
        check("stall_no_push", s_push, 32'h0);
        push_str("b");
        finish = 1'b1;
        run_cycle();
        check("stall_no_pop", s_pop, 32'h0);
        check("stall_no_push2", s_push, 32'h0);
        check("stall_overrun_before", s_ovr, 32'h0);
        run_cycle();
        check("stall_overrun_set", s_ovr, 32'h1);
        check("stall_no_pop2", s_pop, 32'h0);
        bus.out_full = 1'b0;
        run_cycle();
        check("stall_push", s_push, 32'h1);
        run_cycle();
        check("b_pop_after_emit", s_pop, 32'h1);
        check("stall_count", s_count, n_exp);
        finish = 1'b1;
        expect_digest("b");
        run_cycle();
        wait_push("b_latency", 2);
        run_cycle();

        // "foo" aborted (with a finish in the abort cycle), then "a".
        push_str("foo");
        run_cycle();
        run_cycle();
        abort  = 1'b1;
        finish = 1'b1;
        run_cycle();
        check("abort_pop_still", s_pop, 32'h1);
        run_cycle();
        check("abort_msg_len", s_len, 32'h0);
        check("abort_busy", s_busy, 32'h0);
        check("abort_overrun_sticky", s_ovr, 32'h1);
        push_str("a");
        run_cycle();
        finish = 1'b1;
        expect_digest("a");
        run_cycle();
        wait_push("abort_a_latency", 2);
        run_cycle();
        check("abort_a_count", s_count, n_exp);

        // Abort while stalled in EMIT: the push is withdrawn.
        push_str("a");
        run_cycle();
        bus.out_full = 1'b1;
        finish = 1'b1;
        run_cycle();
        run_cycle();
        run_cycle();
        check("abort_stall_state", s_state, 32'h1);
        check("abort_stall_no_push", s_push, 32'h0);
        bus.out_full = 1'b0;
        abort = 1'b1;
        run_cycle();
        check("abort_cancels_push", s_push, 32'h0);
        run_cycle();
        check("abort_stall_back", s_state, 32'h0);
        check("abort_stall_count", s_count, n_exp);
        check("abort_stall_busy", s_busy, 32'h0);
        run_cycle();
        run_cycle();

        // Reset in the middle of "foobar", then "a".
        push_str("foobar");
        run_cycle();
        run_cycle();
        run_cycle();
        reset = 1'b1;
        byte_q.delete();
        n_exp = 0;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        run_cycle();
        check_reset_values("midreset");
        push_str("a");
        run_cycle();
        finish = 1'b1;
        expect_digest("a");
        run_cycle();
        wait_push("midreset_a_latency", 2);
        run_cycle();
        check("midreset_count", s_count, n_exp);

        check("scoreboard_drain", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
